// File: rtl/count_down_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_down_pkg
//  Description : Shared state encoding, BCD constants and the BCD clamp
//                helper for the Count_down timer and display path.
//  Revision    : 1.0  initial release
// ============================================================================
package count_down_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Saturate a nibble into the legal BCD range 0..9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Free-running 0..DIV-1 counter that pulses tick on the last
//                count. en freezes the count, clr forces it back to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int             CW     = $clog2(DIV);
  localparam logic [CW-1:0]  C_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise wrap at the last count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == C_LAST) cnt_d = '0;
      else                 cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = en & ~clr & (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/countdown_bcd_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_bcd_timer
//  Description : Two-digit BCD countdown core. Loads a clamped preset, counts
//                down once per TICK_DIV clocks under start/pause/clear control,
//                holds done at 00 and drives a timed alarm.
//  Revision    : 1.0  initial release
// ============================================================================
module countdown_bcd_timer
  import count_down_pkg::*;
#(
  parameter int TICK_DIV    = 1_000_000,
  parameter int ALARM_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_pause,
  input  logic       clear,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  // A zero-length alarm still needs a one-bit counter to keep widths legal.
  localparam int            AW        = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;
  localparam logic [AW-1:0] ALARM_END = AW'(ALARM_TICKS);
  localparam logic          ALARM_ON  = (ALARM_TICKS > 0);

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          alarm_q, alarm_d;
  logic [AW-1:0] acnt_q, acnt_d;

  logic          sp_prev_q, clr_prev_q;
  logic          start_edge_q, clear_edge_q;

  logic [3:0]    preset_t, preset_o;
  logic          preset_zero;
  logic          tick;
  logic          pre_en, pre_clr;

  assign preset_t    = bcd_clamp(preset_tens);
  assign preset_o    = bcd_clamp(preset_ones);
  assign preset_zero = (preset_t == BCD_ZERO) && (preset_o == BCD_ZERO);

  // Prescaler idles at zero outside counting so every run starts a full period;
  // in PAUSE it simply holds so a resume continues from the same phase.
  assign pre_en  = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign pre_clr = (state_q == ST_IDLE);

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  // Button rising-edge detection; prev resets high so a held button is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_prev_q    <= 1'b1;
      clr_prev_q   <= 1'b1;
      start_edge_q <= 1'b0;
      clear_edge_q <= 1'b0;
    end else begin
      sp_prev_q    <= start_pause;
      clr_prev_q   <= clear;
      start_edge_q <= start_pause & ~sp_prev_q;
      clear_edge_q <= clear & ~clr_prev_q;
    end
  end

  // Next-state, BCD decrement and alarm timing; clear outranks start.
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    case (state_q)
      ST_IDLE: begin
        tens_d  = preset_t;
        ones_d  = preset_o;
        alarm_d = 1'b0;
        acnt_d  = '0;
        if (start_edge_q && !clear_edge_q && !preset_zero) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clear_edge_q) begin
          state_d = ST_IDLE;
          tens_d  = preset_t;
          ones_d  = preset_o;
        end else begin
          if (start_edge_q) state_d = ST_PAUSE;
          if (tick && !((tens_q == BCD_ZERO) && (ones_q == BCD_ZERO))) begin
            if (ones_q != BCD_ZERO) begin
              ones_d = ones_q - 4'd1;
            end else begin
              ones_d = BCD_MAX;
              tens_d = tens_q - 4'd1;
            end
            // Reaching 00 takes precedence over a coincident pause.
            if ((tens_q == BCD_ZERO) && (ones_q == 4'd1)) begin
              state_d = ST_DONE;
              alarm_d = ALARM_ON;
              acnt_d  = '0;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (clear_edge_q) begin
          state_d = ST_IDLE;
          tens_d  = preset_t;
          ones_d  = preset_o;
        end else if (start_edge_q) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        tens_d = BCD_ZERO;
        ones_d = BCD_ZERO;
        if (clear_edge_q || start_edge_q) begin
          state_d = ST_IDLE;
          tens_d  = preset_t;
          ones_d  = preset_o;
          alarm_d = 1'b0;
          acnt_d  = '0;
        end else if (tick && alarm_q) begin
          acnt_d = acnt_q + 1'b1;
          if ((acnt_q + 1'b1) == ALARM_END) alarm_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, digit and alarm registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tens_q  <= BCD_ZERO;
      ones_q  <= BCD_ZERO;
      alarm_q <= 1'b0;
      acnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      alarm_q <= alarm_d;
      acnt_q  <= acnt_d;
    end
  end

  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;
  assign running  = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign alarm    = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_bcd_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_bcd_timer
//  Description : Directed bench for countdown_bcd_timer with TICK_DIV=4,
//                ALARM_TICKS=2 and hand-computed expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_countdown_bcd_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_pause;
  logic       clear;
  logic [3:0] preset_tens;
  logic [3:0] preset_ones;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       running;
  logic       done;
  logic       alarm;

  int total = 0;
  int bad   = 0;

  countdown_bcd_timer #(
    .TICK_DIV    (4),
    .ALARM_TICKS (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_pause (start_pause),
    .clear       (clear),
    .preset_tens (preset_tens),
    .preset_ones (preset_ones),
    .bcd_tens    (bcd_tens),
    .bcd_ones    (bcd_ones),
    .running     (running),
    .done        (done),
    .alarm       (alarm)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] digits();
    return {bcd_tens, bcd_ones};
  endfunction

  initial begin
    rst = 1'b1; start_pause = 1'b0; clear = 1'b0;
    preset_tens = 4'd1; preset_ones = 4'd2;
    cyc(2);
    chk("reset_digits",  digits(),        8'h00);
    chk("reset_running", {7'd0, running}, 8'd0);
    chk("reset_done",    {7'd0, done},    8'd0);
    chk("reset_alarm",   {7'd0, alarm},   8'd0);

    // Test 1: preset 12, count 12 -> 11 -> 10 -> 09
    rst = 1'b0;
    cyc(1);
    chk("t1_preset_load", digits(), 8'h12);
    start_pause = 1'b1;
    cyc(1);
    chk("t1_run_not_yet", {7'd0, running}, 8'd0);
    cyc(1);
    chk("t1_running", {7'd0, running}, 8'd1);
    start_pause = 1'b0;
    cyc(3);
    chk("t1_before_tick", digits(), 8'h12);
    cyc(1);
    chk("t1_step11", digits(), 8'h11);
    cyc(3);
    chk("t1_hold11", digits(), 8'h11);
    cyc(1);
    chk("t1_step10", digits(), 8'h10);
    cyc(4);
    chk("t1_step09", digits(), 8'h09);

    // Test 2: preset 01, expiry, alarm for two ticks, clear back to IDLE
    rst = 1'b1; preset_tens = 4'd0; preset_ones = 4'd1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("t2_preset", digits(), 8'h01);
    start_pause = 1'b1;
    cyc(2);
    chk("t2_running", {7'd0, running}, 8'd1);
    start_pause = 1'b0;
    cyc(3);
    chk("t2_pre_done_digits", digits(), 8'h01);
    chk("t2_pre_done",        {7'd0, done}, 8'd0);
    cyc(1);
    chk("t2_digits00",   digits(),        8'h00);
    chk("t2_done",       {7'd0, done},    8'd1);
    chk("t2_alarm_on",   {7'd0, alarm},   8'd1);
    chk("t2_run_off",    {7'd0, running}, 8'd0);
    cyc(7);
    chk("t2_alarm_still", {7'd0, alarm}, 8'd1);
    cyc(1);
    chk("t2_alarm_off", {7'd0, alarm}, 8'd0);
    chk("t2_done_hold", {7'd0, done},  8'd1);
    clear = 1'b1;
    cyc(2);
    chk("t2_clear_done",   {7'd0, done}, 8'd0);
    chk("t2_clear_digits", digits(),     8'h01);
    clear = 1'b0;

    // Test 3: preset 20, pause at prescaler count 2, resume
    rst = 1'b1; preset_tens = 4'd2; preset_ones = 4'd0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    start_pause = 1'b1;
    cyc(1);
    start_pause = 1'b0;
    cyc(1);
    chk("t3_running", {7'd0, running}, 8'd1);
    start_pause = 1'b1;
    cyc(1);
    start_pause = 1'b0;
    cyc(1);
    chk("t3_paused", {7'd0, running}, 8'd0);
    cyc(20);
    chk("t3_pause_hold", digits(), 8'h20);
    start_pause = 1'b1;
    cyc(1);
    start_pause = 1'b0;
    cyc(2);
    chk("t3_resumed",     {7'd0, running}, 8'd1);
    chk("t3_before_step", digits(),        8'h20);
    cyc(1);
    chk("t3_step19", digits(), 8'h19);

    // Test 4: clear and start together during RUN; preset tens 4'hC clamps to 9
    preset_tens = 4'hC; preset_ones = 4'd3;
    start_pause = 1'b1; clear = 1'b1;
    cyc(2);
    chk("t4_idle",   {7'd0, running}, 8'd0);
    chk("t4_digits", digits(),        8'h93);
    chk("t4_done",   {7'd0, done},    8'd0);

    // Test 5: preset C/F clamps to 99; ten ticks give 89
    start_pause = 1'b0; clear = 1'b0;
    preset_tens = 4'hC; preset_ones = 4'hF;
    cyc(1);
    chk("t5_clamp99", digits(), 8'h99);
    start_pause = 1'b1;
    cyc(1);
    start_pause = 1'b0;
    cyc(1);
    chk("t5_running", {7'd0, running}, 8'd1);
    cyc(39);
    chk("t5_nine_ticks", digits(), 8'h90);
    cyc(1);
    chk("t5_ten_ticks", digits(), 8'h89);

    // Test 6: reset mid-alarm, then button held through reset
    rst = 1'b1; preset_tens = 4'd0; preset_ones = 4'd1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    start_pause = 1'b1;
    cyc(1);
    start_pause = 1'b0;
    cyc(5);
    chk("t6_alarm_on", {7'd0, alarm}, 8'd1);
    cyc(2);
    rst = 1'b1; start_pause = 1'b1;
    cyc(1);
    chk("t6_rst_digits", digits(),      8'h00);
    chk("t6_rst_done",   {7'd0, done},  8'd0);
    chk("t6_rst_alarm",  {7'd0, alarm}, 8'd0);
    cyc(1);
    rst = 1'b0;
    cyc(6);
    chk("t6_held_no_start", {7'd0, running}, 8'd0);
    chk("t6_held_digits",   digits(),        8'h01);
    start_pause = 1'b0;
    cyc(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
